cajero_gen: RTL and testbench
=============================

# cajero_gen

Parametrised ATM transaction controller, successor to the fixed-width `cajero`. It handles card session start, serial PIN entry through a digit strobe, a configurable attempt limit with warning and lockout, and deposit/withdraw execution against an internal balance register. Beyond `cajero`, it adds a cumulative withdrawal limit, an inactivity timeout and deposit-overflow protection. It sits between the keypad/card front-end and the cash dispenser, driven by the `provador` style of stimulus.

## Interface
- `PIN_DIGITS`, 4: number of 4-bit PIN digits.
- `MAX_TRIES`, 3: wrong-PIN attempts before lockout (≥2).
- `MONTO_W`, 32: amount width.
- `BAL_W`, 64: balance width (≥ `MONTO_W`+1).
- `LIMITE_RETIRO`, 500000: maximum cumulative withdrawals since reset.
- `TIMEOUT_CYC`, 1000: idle cycles allowed in PIN or amount entry.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `TARJETA_RECIBIDA`  in  1  card present; sampled in IDLE.
- `TIPO_TRANS`  in  1  0 = deposit, 1 = withdraw; sampled with `TARJETA_RECIBIDA`.
- `PIN`  in  4*`PIN_DIGITS`  stored PIN, most significant digit first.
- `DIGITO`  in  4  keyed digit.
- `DIGITO_STB`  in  1  one-cycle strobe validating `DIGITO`.
- `MONTO`  in  `MONTO_W`  transaction amount.
- `MONTO_STB`  in  1  one-cycle strobe validating `MONTO`.
- `BALANCE_INICIAL`  in  `BAL_W`  balance loaded after reset.
- `BALANCE`  out  `BAL_W`  current balance.
- `BALANCE_ACTUALIZADO`  out  1  pulse: balance changed.
- `ENTREGAR_DINERO`  out  1  pulse: dispense withdrawal.
- `PIN_INCORRECTO`  out  1  pulse: PIN mismatch.
- `ADVERTENCIA`  out  1  level: one attempt remaining.
- `BLOQUEO`  out  1  level: locked until reset.
- `FONDOS_INSUFICIENTES`  out  1  pulse: withdrawal exceeds balance.
- `LIMITE_EXCEDIDO`  out  1  pulse: cumulative limit exceeded or deposit overflow.
- `TIMEOUT`  out  1  pulse: session abandoned for inactivity.

## Operation
- **States:** INIT, IDLE, PIN_ENTRY, PIN_CHECK, WAIT_MONTO, EXEC, BLOCKED.
- **Reset:** every output is 0, `BALANCE` is 0, all counters are 0, and the FSM is in INIT.
- **INIT:** on the first edge after reset release, `BALANCE` ← `BALANCE_INICIAL`; go to IDLE.
- **IDLE:** if `TARJETA_RECIBIDA`=1, latch `TIPO_TRANS`, clear the digit count and timer, and go to PIN_ENTRY. Strobes in IDLE are ignored.
- **PIN_ENTRY:**
  - Each `DIGITO_STB` shifts `DIGITO` into the entry register and increments the digit count.
  - When the count reaches `PIN_DIGITS`, go to PIN_CHECK.
  - `MONTO_STB` is ignored here.
- **PIN_CHECK** (1 cycle):
  - On a match, clear the try counter, deassert `ADVERTENCIA`, and go to WAIT_MONTO.
  - On a mismatch, pulse `PIN_INCORRECTO` and increment tries.
  - If tries = `MAX_TRIES`-1, set `ADVERTENCIA`.
  - If tries = `MAX_TRIES`, set `BLOQUEO`, clear `ADVERTENCIA`, and go to BLOCKED; otherwise return to PIN_ENTRY with the digit count cleared.
- **WAIT_MONTO:** on `MONTO_STB`, latch `MONTO` and go to EXEC. `DIGITO_STB` is ignored here.
- **EXEC** (1 cycle), then IDLE:
  - Deposit: if `BALANCE`+`MONTO` overflows `BAL_W`, pulse `LIMITE_EXCEDIDO`. Otherwise add and pulse `BALANCE_ACTUALIZADO`.
  - Withdraw, checks in priority order:
    - `MONTO` > `BALANCE` → pulse `FONDOS_INSUFICIENTES`.
    - Else acumulado+`MONTO` > `LIMITE_RETIRO` → pulse `LIMITE_EXCEDIDO`.
    - Else subtract, add to acumulado, and pulse `ENTREGAR_DINERO` and `BALANCE_ACTUALIZADO` together.
  - The acumulado register is `BAL_W` wide and cleared only by reset.
- **Timeout:**
  - The timer increments each cycle in PIN_ENTRY and WAIT_MONTO, and clears on any accepted strobe or state change.
  - When it reaches `TIMEOUT_CYC`, pulse `TIMEOUT` and go to IDLE.
  - The try counter and `ADVERTENCIA` are retained across a timeout.
- **BLOCKED:** absorbing; all inputs are ignored, and only `rst` exits.

## Timing
- All outputs are registered and change on the clock edge that follows the causing input edge.
- Pulses last exactly one cycle.
- `ADVERTENCIA` and `BLOQUEO` are levels.
- PIN latency: the result pulse or transition appears 2 edges after the last `DIGITO_STB` is sampled (PIN_ENTRY→PIN_CHECK, then PIN_CHECK output).
- EXEC latency: outputs and the `BALANCE` update appear 2 edges after `MONTO_STB` is sampled.
- `BALANCE` updates on the same edge as `BALANCE_ACTUALIZADO`.
- Simultaneous strobes: whichever strobe belongs to the current state is accepted; the other is dropped.
- A strobe on the same edge as the timeout threshold wins: the timer clears and `TIMEOUT` does not pulse.
- `rst` asserted mid-session: immediate asynchronous return to the reset values above, including the lockout.

## Test plan
- **Correct withdrawal:** `PIN`=16'h1234, `BALANCE_INICIAL`=1000, withdraw, digits 1,2,3,4, `MONTO`=300 → `ENTREGAR_DINERO` and `BALANCE_ACTUALIZADO` pulse 2 cycles after `MONTO_STB`; `BALANCE`=700.
- **Lockout path:** three wrong PINs with `MAX_TRIES`=3 → `PIN_INCORRECTO` pulses ×3; `ADVERTENCIA` rises after the 2nd; after the 3rd `BLOQUEO`=1 and `ADVERTENCIA`=0; a later correct PIN has no effect; `rst` clears everything.
- **Withdrawal rejections:** `MONTO`=1500 against balance 1000 → `FONDOS_INSUFICIENTES` only, `BALANCE` unchanged. With `LIMITE_RETIRO`=500, withdraw 400 then 200 → second gives `LIMITE_EXCEDIDO`, `BALANCE`=600.
- **Deposit and overflow:** deposit 250 → `BALANCE`=1250. `BAL_W`=33, `BALANCE_INICIAL`=2^33−10, deposit 20 → `LIMITE_EXCEDIDO`, `BALANCE` unchanged.
- **Timeout:** `TIMEOUT_CYC`=8, enter 2 digits then stay idle → `TIMEOUT` pulse on the 8th idle cycle, FSM back in IDLE, tries unchanged. A strobe on cycle 8 → no timeout.
- **Reset mid-entry:** `rst`=0 after 3 digits → all outputs 0 immediately; after release, `BALANCE`=`BALANCE_INICIAL` one edge later.

Source files
------------

// File: rtl/cajero_gen.sv
// -----------------------------------------------------------------------------
// cajero_gen - parametrised ATM transaction controller.
//
// Handles the card session, serial PIN entry, the wrong-PIN warning and lockout,
// and deposit/withdraw execution against an internal balance. It also enforces a
// cumulative withdrawal limit, an inactivity timeout and deposit-overflow
// protection.
//
// Ports:
//   clk                  sole clock, rising edge
//   rst                  asynchronous active-low reset
//   TARJETA_RECIBIDA     card present (sampled in IDLE)
//   TIPO_TRANS           0 = deposit, 1 = withdraw (sampled with the card)
//   PIN                  stored PIN, most significant digit first
//   DIGITO/DIGITO_STB    keyed digit and its one-cycle strobe
//   MONTO/MONTO_STB      transaction amount and its one-cycle strobe
//   BALANCE_INICIAL      balance loaded on the first edge after reset
//   BALANCE              current balance
//   BALANCE_ACTUALIZADO  pulse: balance changed
//   ENTREGAR_DINERO      pulse: dispense a withdrawal
//   PIN_INCORRECTO       pulse: PIN mismatch
//   ADVERTENCIA          level: one attempt remaining
//   BLOQUEO              level: locked until reset
//   FONDOS_INSUFICIENTES pulse: withdrawal exceeds balance
//   LIMITE_EXCEDIDO      pulse: cumulative limit exceeded or deposit overflow
//   TIMEOUT              pulse: session abandoned for inactivity
// -----------------------------------------------------------------------------
module cajero_gen #(
    parameter int unsigned     PIN_DIGITS    = 4,
    parameter int unsigned     MAX_TRIES     = 3,
    parameter int unsigned     MONTO_W       = 32,
    parameter int unsigned     BAL_W         = 64,
    parameter longint unsigned LIMITE_RETIRO = 500000,
    parameter int unsigned     TIMEOUT_CYC   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    TARJETA_RECIBIDA,
    input  logic                    TIPO_TRANS,
    input  logic [4*PIN_DIGITS-1:0] PIN,
    input  logic [3:0]              DIGITO,
    input  logic                    DIGITO_STB,
    input  logic [MONTO_W-1:0]      MONTO,
    input  logic                    MONTO_STB,
    input  logic [BAL_W-1:0]        BALANCE_INICIAL,
    output logic [BAL_W-1:0]        BALANCE,
    output logic                    BALANCE_ACTUALIZADO,
    output logic                    ENTREGAR_DINERO,
    output logic                    PIN_INCORRECTO,
    output logic                    ADVERTENCIA,
    output logic                    BLOQUEO,
    output logic                    FONDOS_INSUFICIENTES,
    output logic                    LIMITE_EXCEDIDO,
    output logic                    TIMEOUT
);

    localparam int unsigned PIN_W = 4 * PIN_DIGITS;
    localparam int unsigned DIG_W = $clog2(PIN_DIGITS + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BAL_W:0] LIMITE = (BAL_W + 1)'(LIMITE_RETIRO);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_PIN_ENTRY, S_PIN_CHECK, S_WAIT_MONTO, S_EXEC, S_BLOCKED
    } state_t;

    state_t             r_state, w_nxt_state;
    logic               r_tipo, w_nxt_tipo;
    logic [PIN_W-1:0]   r_entry, w_nxt_entry;
    logic [DIG_W-1:0]   r_digits, w_nxt_digits;
    logic [TRY_W-1:0]   r_tries, w_nxt_tries;
    logic [TMR_W-1:0]   r_timer, w_nxt_timer;
    logic [MONTO_W-1:0] r_monto, w_nxt_monto;
    logic [BAL_W-1:0]   r_bal, w_nxt_bal;
    logic [BAL_W-1:0]   r_acum, w_nxt_acum;
    logic               r_adv, w_nxt_adv;
    logic               r_bloq, w_nxt_bloq;
    logic               r_act, w_nxt_act;
    logic               r_ent, w_nxt_ent;
    logic               r_pin_inc, w_nxt_pin_inc;
    logic               r_fondos, w_nxt_fondos;
    logic               r_limite, w_nxt_limite;
    logic               r_timeout, w_nxt_timeout;

    // Amount arithmetic is done one bit wider than the balance so the deposit
    // carry and the cumulative-limit comparison never wrap.
    logic [BAL_W:0]     w_monto_ext;
    logic [BAL_W:0]     w_dep_sum;
    logic [BAL_W:0]     w_acum_sum;
    logic [TRY_W-1:0]   w_tries_inc;
    logic               w_idle_expired;

    assign w_monto_ext    = (BAL_W + 1)'(r_monto);
    assign w_dep_sum      = {1'b0, r_bal} + w_monto_ext;
    assign w_acum_sum     = {1'b0, r_acum} + w_monto_ext;
    assign w_tries_inc    = r_tries + 1'b1;
    assign w_idle_expired = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_tipo    = r_tipo;
        w_nxt_entry   = r_entry;
        w_nxt_digits  = r_digits;
        w_nxt_tries   = r_tries;
        w_nxt_timer   = '0;
        w_nxt_monto   = r_monto;
        w_nxt_bal     = r_bal;
        w_nxt_acum    = r_acum;
        w_nxt_adv     = r_adv;
        w_nxt_bloq    = r_bloq;
        w_nxt_act     = 1'b0;
        w_nxt_ent     = 1'b0;
        w_nxt_pin_inc = 1'b0;
        w_nxt_fondos  = 1'b0;
        w_nxt_limite  = 1'b0;
        w_nxt_timeout = 1'b0;

        case (r_state)
            S_INIT: begin
                w_nxt_bal   = BALANCE_INICIAL;
                w_nxt_state = S_IDLE;
            end
            S_IDLE: begin
                if (TARJETA_RECIBIDA) begin
                    w_nxt_tipo   = TIPO_TRANS;
                    w_nxt_digits = '0;
                    w_nxt_state  = S_PIN_ENTRY;
                end
            end
            S_PIN_ENTRY: begin
                // An accepted strobe beats the timeout on the threshold edge.
                if (DIGITO_STB) begin
                    w_nxt_entry = (r_entry << 4) | PIN_W'(DIGITO);
                    if (r_digits == DIG_W'(PIN_DIGITS - 1)) begin
                        w_nxt_digits = '0;
                        w_nxt_state  = S_PIN_CHECK;
                    end else begin
                        w_nxt_digits = r_digits + 1'b1;
                    end
                end else if (w_idle_expired) begin
                    w_nxt_timeout = 1'b1;
                    w_nxt_state   = S_IDLE;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            S_PIN_CHECK: begin
                if (r_entry == PIN) begin
                    w_nxt_tries = '0;
                    w_nxt_adv   = 1'b0;
                    w_nxt_state = S_WAIT_MONTO;
                end else begin
                    w_nxt_pin_inc = 1'b1;
                    w_nxt_tries   = w_tries_inc;
                    if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                        w_nxt_bloq  = 1'b1;
                        w_nxt_adv   = 1'b0;
                        w_nxt_state = S_BLOCKED;
                    end else begin
                        if (w_tries_inc == TRY_W'(MAX_TRIES - 1))
                            w_nxt_adv = 1'b1;
                        w_nxt_digits = '0;
                        w_nxt_state  = S_PIN_ENTRY;
                    end
                end
            end
            S_WAIT_MONTO: begin
                if (MONTO_STB) begin
                    w_nxt_monto = MONTO;
                    w_nxt_state = S_EXEC;
                end else if (w_idle_expired) begin
                    w_nxt_timeout = 1'b1;
                    w_nxt_state   = S_IDLE;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            S_EXEC: begin
                w_nxt_state = S_IDLE;
                if (!r_tipo) begin
                    if (w_dep_sum[BAL_W]) begin
                        w_nxt_limite = 1'b1;
                    end else begin
                        w_nxt_bal = w_dep_sum[BAL_W-1:0];
                        w_nxt_act = 1'b1;
                    end
                end else if (w_monto_ext > {1'b0, r_bal}) begin
                    w_nxt_fondos = 1'b1;
                end else if (w_acum_sum > LIMITE) begin
                    w_nxt_limite = 1'b1;
                end else begin
                    w_nxt_bal  = r_bal - BAL_W'(r_monto);
                    w_nxt_acum = w_acum_sum[BAL_W-1:0];
                    w_nxt_ent  = 1'b1;
                    w_nxt_act  = 1'b1;
                end
            end
            S_BLOCKED: begin
                w_nxt_state = S_BLOCKED;
            end
            default: begin
                w_nxt_state = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_INIT;
            r_tipo    <= 1'b0;
            r_entry   <= '0;
            r_digits  <= '0;
            r_tries   <= '0;
            r_timer   <= '0;
            r_monto   <= '0;
            r_bal     <= '0;
            r_acum    <= '0;
            r_adv     <= 1'b0;
            r_bloq    <= 1'b0;
            r_act     <= 1'b0;
            r_ent     <= 1'b0;
            r_pin_inc <= 1'b0;
            r_fondos  <= 1'b0;
            r_limite  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_tipo    <= w_nxt_tipo;
            r_entry   <= w_nxt_entry;
            r_digits  <= w_nxt_digits;
            r_tries   <= w_nxt_tries;
            r_timer   <= w_nxt_timer;
            r_monto   <= w_nxt_monto;
            r_bal     <= w_nxt_bal;
            r_acum    <= w_nxt_acum;
            r_adv     <= w_nxt_adv;
            r_bloq    <= w_nxt_bloq;
            r_act     <= w_nxt_act;
            r_ent     <= w_nxt_ent;
            r_pin_inc <= w_nxt_pin_inc;
            r_fondos  <= w_nxt_fondos;
            r_limite  <= w_nxt_limite;
            r_timeout <= w_nxt_timeout;
        end
    end

    assign BALANCE              = r_bal;
    assign BALANCE_ACTUALIZADO  = r_act;
    assign ENTREGAR_DINERO      = r_ent;
    assign PIN_INCORRECTO       = r_pin_inc;
    assign ADVERTENCIA          = r_adv;
    assign BLOQUEO              = r_bloq;
    assign FONDOS_INSUFICIENTES = r_fondos;
    assign LIMITE_EXCEDIDO      = r_limite;
    assign TIMEOUT              = r_timeout;

endmodule

// File: tb/tb_cajero_gen.sv
// -----------------------------------------------------------------------------
// tb_cajero_gen - self-checking bench for cajero_gen.
// A transaction-level account model (balance, withdrawn total, tries, lock)
// predicts every output; directed scenarios are followed by random sessions.
// -----------------------------------------------------------------------------
module tb_cajero_gen;

    localparam int unsigned     BW  = 33;
    localparam int unsigned     MW  = 32;
    localparam int unsigned     NTRY = 3;
    localparam longint unsigned LIM = 500;
    localparam int unsigned     TO  = 8;
    localparam longint unsigned BAL_MAX = (64'd1 << BW) - 64'd1;

    // Output vector layout: {ACT, ENT, PIN_INC, ADV, BLOQ, FONDOS, LIMITE, TIMEOUT}
    localparam logic [7:0] LVL_MASK = 8'b0001_1000;
    localparam logic [7:0] O_ACT = 8'h80, O_ENT = 8'h40, O_PIN = 8'h20;
    localparam logic [7:0] O_FON = 8'h04, O_LIM = 8'h02, O_TO  = 8'h01;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          TARJETA_RECIBIDA = 1'b0;
    logic          TIPO_TRANS = 1'b0;
    logic [15:0]   PIN = 16'h1234;
    logic [3:0]    DIGITO = '0;
    logic          DIGITO_STB = 1'b0;
    logic [MW-1:0] MONTO = '0;
    logic          MONTO_STB = 1'b0;
    logic [BW-1:0] BALANCE_INICIAL = '0;
    logic [BW-1:0] BALANCE;
    logic BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO, ADVERTENCIA;
    logic BLOQUEO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO, TIMEOUT;
    logic [7:0]    w_outs;

    always #5 clk = ~clk;

    cajero_gen #(
        .PIN_DIGITS(4), .MAX_TRIES(NTRY), .MONTO_W(MW), .BAL_W(BW),
        .LIMITE_RETIRO(LIM), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_TRANS(TIPO_TRANS),
        .PIN(PIN), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
        .MONTO(MONTO), .MONTO_STB(MONTO_STB),
        .BALANCE_INICIAL(BALANCE_INICIAL), .BALANCE(BALANCE),
        .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
        .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
        .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .LIMITE_EXCEDIDO(LIMITE_EXCEDIDO),
        .TIMEOUT(TIMEOUT)
    );

    assign w_outs = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO, ADVERTENCIA,
                     BLOQUEO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO, TIMEOUT};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Account model
    longint unsigned m_bal, m_acum;
    int unsigned     m_tries;
    bit              m_adv, m_lock, m_tipo;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lvl();
        return {3'b000, m_adv, m_lock, 3'b000};
    endfunction

    // Check outputs now, then one cycle later that pulses dropped and levels held.
    task automatic expect_outs(input string tag, input logic [7:0] exp);
        chk(tag, {56'd0, w_outs}, {56'd0, exp});
        chk({tag, "/bal"}, {31'd0, BALANCE}, m_bal);
        @(negedge clk);
        chk({tag, "/next"}, {56'd0, w_outs}, {56'd0, exp & LVL_MASK});
    endtask

    task automatic do_reset(input longint unsigned init);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_outs", {56'd0, w_outs}, 64'd0);
        chk("rst_bal", {31'd0, BALANCE}, 64'd0);
        BALANCE_INICIAL = BW'(init);
        TARJETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_bal = init; m_acum = 0; m_tries = 0; m_adv = 0; m_lock = 0;
        chk("init_bal", {31'd0, BALANCE}, m_bal);
        chk("init_outs", {56'd0, w_outs}, 64'd0);
    endtask

    task automatic card(input bit tipo);
        @(negedge clk);
        TARJETA_RECIBIDA = 1'b1; TIPO_TRANS = tipo;
        @(negedge clk);
        TARJETA_RECIBIDA = 1'b0;
        if (!m_lock) m_tipo = tipo;
    endtask

    task automatic key_digit(input logic [3:0] d, input int unsigned gap, input bit both);
        @(negedge clk);
        DIGITO = d; DIGITO_STB = 1'b1; MONTO_STB = both; MONTO = $urandom;
        @(negedge clk);
        DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic model_pin(input logic [15:0] code, output logic [7:0] exp, output bit ok);
        ok = 0;
        exp = lvl();
        if (!m_lock) begin
            if (code == PIN) begin
                m_tries = 0; m_adv = 0; ok = 1;
                exp = lvl();
            end else begin
                m_tries++;
                if (m_tries == NTRY - 1) m_adv = 1;
                if (m_tries == NTRY) begin m_lock = 1; m_adv = 0; end
                exp = lvl() | O_PIN;
            end
        end
    endtask

    task automatic model_exec(input longint unsigned m, output logic [7:0] exp);
        exp = lvl();
        if (m_lock) begin
            exp = lvl();
        end else if (!m_tipo) begin
            if (m_bal + m > BAL_MAX) exp |= O_LIM;
            else begin m_bal += m; exp |= O_ACT; end
        end else if (m > m_bal) begin
            exp |= O_FON;
        end else if (m_acum + m > LIM) begin
            exp |= O_LIM;
        end else begin
            m_bal -= m; m_acum += m;
            exp |= O_ACT | O_ENT;
        end
    endtask

    task automatic pin_attempt(input string tag, input logic [15:0] code, input int unsigned gap,
                               input bit both, output bit ok);
        logic [7:0] exp;
        for (int i = 0; i < 4; i++)
            key_digit(code[15-4*i -: 4], (i == 3) ? 0 : gap, both);
        @(negedge clk);
        model_pin(code, exp, ok);
        expect_outs(tag, exp);
    endtask

    task automatic send_monto(input string tag, input longint unsigned m, input bit both);
        logic [7:0] exp;
        @(negedge clk);
        MONTO = MW'(m); MONTO_STB = 1'b1; DIGITO_STB = both; DIGITO = 4'($urandom);
        @(negedge clk);
        MONTO_STB = 1'b0; DIGITO_STB = 1'b0;
        @(negedge clk);
        model_exec(m, exp);
        expect_outs(tag, exp);
    endtask

    task automatic session(input string tag, input bit tipo, input longint unsigned m);
        bit ok;
        card(tipo);
        pin_attempt({tag, "/pin"}, PIN, 0, 0, ok);
        chk({tag, "/pin_ok"}, {63'd0, ok}, 64'd1);
        send_monto(tag, m, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        logic [15:0] code;
        m_bal = 0; m_acum = 0; m_tries = 0; m_adv = 0; m_lock = 0; m_tipo = 0;
        repeat (2) @(negedge clk);

        // Correct withdrawal
        do_reset(1000);
        session("wd300", 1, 300);

        // Withdrawal rejections: insufficient funds, then cumulative limit
        do_reset(1000);
        session("wd1500", 1, 1500);
        session("wd400", 1, 400);
        session("wd200", 1, 200);

        // Boundaries: withdraw whole balance reaching the limit exactly, then exceed it
        do_reset(500);
        session("wd_all", 1, 500);
        session("dep1", 0, 1);
        session("wd_lim1", 1, 1);

        // Deposit and overflow
        do_reset(1000);
        session("dep250", 0, 250);
        do_reset(BAL_MAX - 9);
        session("dep20_ovf", 0, 20);
        session("dep9_max", 0, 9);
        session("dep1_ovf", 0, 1);

        // Lockout
        do_reset(1000);
        card(1);
        pin_attempt("bad1", 16'h1235, 0, 0, ok);
        pin_attempt("bad2", 16'h4321, 0, 0, ok);
        pin_attempt("bad3", 16'h0000, 0, 0, ok);
        pin_attempt("locked_pin", PIN, 0, 0, ok);
        send_monto("locked_monto", 300, 0);
        card(1);
        pin_attempt("locked_pin2", PIN, 0, 0, ok);
        do_reset(1000);

        // Timeout after two digits; tries retained
        card(1);
        pin_attempt("to_bad", 16'h9999, 0, 0, ok);
        key_digit(4'h1, 0, 0);
        key_digit(4'h2, 0, 0);
        repeat (7) @(negedge clk);
        chk("to_early", {56'd0, w_outs}, {56'd0, lvl()});
        @(negedge clk);
        expect_outs("timeout", lvl() | O_TO);
        // Back in IDLE: digits without a card do nothing
        for (int i = 0; i < 4; i++) key_digit(4'h5, 0, 0);
        @(negedge clk);
        chk("idle_ignores", {56'd0, w_outs}, {56'd0, lvl()});
        card(1);
        pin_attempt("to_bad2", 16'h8888, 0, 0, ok);
        pin_attempt("to_ok", PIN, 0, 0, ok);
        send_monto("to_wd", 100, 0);

        // Strobe on the threshold edge suppresses the timeout
        card(1);
        key_digit(4'h1, 0, 0);
        key_digit(4'h2, 0, 0);
        repeat (6) @(negedge clk);
        key_digit(4'h3, 0, 0);
        chk("stb_at_thr", {56'd0, w_outs}, {56'd0, lvl()});
        key_digit(4'h4, 0, 0);
        @(negedge clk);
        begin
            logic [7:0] exp;
            model_pin(16'h1234, exp, ok);
            expect_outs("thr_pin", exp);
        end
        send_monto("thr_dep", 77, 0);

        // Reset mid-entry with the warning raised
        do_reset(1000);
        card(0);
        pin_attempt("mid_bad1", 16'h1111, 0, 0, ok);
        pin_attempt("mid_bad2", 16'h2222, 0, 0, ok);
        for (int i = 0; i < 3; i++) key_digit(4'(i + 1), 0, 0);
        do_reset(777);

        // Random sessions
        for (int s = 0; s < 40; s++) begin
            if (m_lock || m_acum > 400 || $urandom_range(0, 9) == 0) begin
                PIN = 16'($urandom);
                do_reset($urandom_range(0, 3000));
            end
            card(1'($urandom_range(0, 1)));
            ok = 0;
            while (!ok && !m_lock) begin
                code = ($urandom_range(0, 3) == 0) ? (PIN ^ (16'h1 << $urandom_range(0, 15))) : PIN;
                pin_attempt("rnd_pin", code, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ok);
            end
            if (ok) send_monto("rnd_exec", $urandom_range(0, 1500), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
